// File: rtl/apb_timer_slave.sv
// APB2 timer peripheral: a register bank around a prescaled down-counter
// that raises a level interrupt on expiry.
`timescale 1ns/1ps
module apb_timer_slave #(
  parameter logic [31:0] BASE_ADDR = 32'h0000_0000,
  parameter int          CNT_W     = 32,
  parameter int          PRESC_W   = 8
) (
  input  logic        hclk,
  input  logic        hresetn,
  input  logic        psel,
  input  logic        penable,
  input  logic        pwrite,
  input  logic [31:0] paddr,
  input  logic [31:0] pwdata,
  output logic [31:0] prdata,
  output logic        irq
);

  localparam logic [5:0] OFF_CTRL    = 6'h00;
  localparam logic [5:0] OFF_LOAD    = 6'h01;
  localparam logic [5:0] OFF_COUNT   = 6'h02;
  localparam logic [5:0] OFF_STATUS  = 6'h03;
  localparam logic [5:0] OFF_PRESC   = 6'h04;
  localparam logic [5:0] OFF_SCRATCH = 6'h05;

  localparam int EN_BIT   = 0;
  localparam int AUTO_BIT = 1;
  localparam int IE_BIT   = 2;

  localparam logic [CNT_W-1:0]   CNT_ONE   = CNT_W'(1'b1);
  localparam logic [CNT_W-1:0]   CNT_ZERO  = CNT_W'(1'b0);
  localparam logic [PRESC_W-1:0] PRESC_ONE  = PRESC_W'(1'b1);
  localparam logic [PRESC_W-1:0] PRESC_ZERO = PRESC_W'(1'b0);

  logic [2:0]         ctrl_q,      ctrl_d;
  logic [CNT_W-1:0]   load_q,      load_d;
  logic [CNT_W-1:0]   count_q,     count_d;
  logic               exp_q,       exp_d;
  logic [PRESC_W-1:0] presc_q,     presc_d;
  logic [31:0]        scratch_q,   scratch_d;
  logic [PRESC_W-1:0] presc_cnt_q, presc_cnt_d;
  logic [31:0]        prdata_q,    prdata_d;

  logic             hit_s;
  logic [5:0]       reg_idx_s;
  logic             wr_s;
  logic             rd_setup_s;
  logic             wr_ctrl_s;
  logic             wr_load_s;
  logic             wr_status_s;
  logic             wr_presc_s;
  logic             wr_scratch_s;
  logic             tick_s;
  logic             expire_s;
  logic [CNT_W-1:0] reload_s;
  logic [31:0]      rd_data_s;
  logic             unused_s;

  assign hit_s      = (paddr[31:8] == BASE_ADDR[31:8]);
  assign reg_idx_s  = paddr[7:2];
  assign wr_s       = psel & penable & pwrite & hit_s;
  assign rd_setup_s = psel & ~penable & ~pwrite;
  assign unused_s   = ^paddr[1:0];

  // Tick and expiry depend only on flops, so irq cannot glitch from the bus
  assign tick_s   = ctrl_q[EN_BIT] & (presc_cnt_q == presc_q);
  assign expire_s = tick_s & (count_q <= CNT_ONE);

  // Write strobe decode for the access-phase commit edge
  always_comb begin
    wr_ctrl_s    = 1'b0;
    wr_load_s    = 1'b0;
    wr_status_s  = 1'b0;
    wr_presc_s   = 1'b0;
    wr_scratch_s = 1'b0;
    if (wr_s) begin
      case (reg_idx_s)
        OFF_CTRL:    wr_ctrl_s    = 1'b1;
        OFF_LOAD:    wr_load_s    = 1'b1;
        OFF_STATUS:  wr_status_s  = 1'b1;
        OFF_PRESC:   wr_presc_s   = 1'b1;
        OFF_SCRATCH: wr_scratch_s = 1'b1;
        default:     wr_ctrl_s    = 1'b0;
      endcase
    end else begin
      wr_ctrl_s = 1'b0;
    end
  end

  // Read mux; unmapped offsets and foreign bases return zero
  always_comb begin
    rd_data_s = 32'h0000_0000;
    if (hit_s) begin
      case (reg_idx_s)
        OFF_CTRL:    rd_data_s[2:0]         = ctrl_q;
        OFF_LOAD:    rd_data_s[CNT_W-1:0]   = load_q;
        OFF_COUNT:   rd_data_s[CNT_W-1:0]   = count_q;
        OFF_STATUS:  rd_data_s[0]           = exp_q;
        OFF_PRESC:   rd_data_s[PRESC_W-1:0] = presc_q;
        OFF_SCRATCH: rd_data_s              = scratch_q;
        default:     rd_data_s              = 32'h0000_0000;
      endcase
    end else begin
      rd_data_s = 32'h0000_0000;
    end
  end

  // Next-state for the register bank, prescaler and down-counter
  always_comb begin
    ctrl_d      = ctrl_q;
    load_d      = load_q;
    count_d     = count_q;
    exp_d       = exp_q;
    presc_d     = presc_q;
    scratch_d   = scratch_q;
    presc_cnt_d = presc_cnt_q;
    prdata_d    = prdata_q;
    reload_s    = wr_load_s ? pwdata[CNT_W-1:0] : load_q;

    // A CTRL write overrides the one-shot auto-disable in the same cycle
    if (wr_ctrl_s) begin
      ctrl_d = pwdata[2:0];
    end else if (expire_s && !ctrl_q[AUTO_BIT]) begin
      ctrl_d[EN_BIT] = 1'b0;
    end else begin
      ctrl_d = ctrl_q;
    end

    if (wr_load_s) begin
      load_d = pwdata[CNT_W-1:0];
    end else begin
      load_d = load_q;
    end

    if (wr_load_s && !ctrl_q[EN_BIT]) begin
      count_d = pwdata[CNT_W-1:0];
    end else if (tick_s) begin
      if (count_q > CNT_ONE) begin
        count_d = count_q - CNT_ONE;
      end else if (ctrl_q[AUTO_BIT]) begin
        count_d = reload_s;
      end else begin
        count_d = CNT_ZERO;
      end
    end else begin
      count_d = count_q;
    end

    // Expiry set beats a simultaneous W1C
    if (expire_s) begin
      exp_d = 1'b1;
    end else if (wr_status_s && pwdata[0]) begin
      exp_d = 1'b0;
    end else begin
      exp_d = exp_q;
    end

    if (wr_presc_s) begin
      presc_d = pwdata[PRESC_W-1:0];
    end else begin
      presc_d = presc_q;
    end

    if (wr_scratch_s) begin
      scratch_d = pwdata;
    end else begin
      scratch_d = scratch_q;
    end

    if (wr_ctrl_s && pwdata[EN_BIT] && !ctrl_q[EN_BIT]) begin
      presc_cnt_d = PRESC_ZERO;
    end else if (tick_s) begin
      presc_cnt_d = PRESC_ZERO;
    end else if (ctrl_q[EN_BIT]) begin
      presc_cnt_d = presc_cnt_q + PRESC_ONE;
    end else begin
      presc_cnt_d = presc_cnt_q;
    end

    // prdata captures the pre-edge register value at the read setup edge
    if (rd_setup_s) begin
      prdata_d = rd_data_s;
    end else begin
      prdata_d = prdata_q;
    end
  end

  // State registers with asynchronous active-high reset
  always_ff @(posedge hclk or posedge hresetn) begin
    if (hresetn) begin
      ctrl_q      <= 3'b000;
      load_q      <= CNT_ZERO;
      count_q     <= CNT_ZERO;
      exp_q       <= 1'b0;
      presc_q     <= PRESC_ZERO;
      scratch_q   <= 32'h0000_0000;
      presc_cnt_q <= PRESC_ZERO;
      prdata_q    <= 32'h0000_0000;
    end else begin
      ctrl_q      <= ctrl_d;
      load_q      <= load_d;
      count_q     <= count_d;
      exp_q       <= exp_d;
      presc_q     <= presc_d;
      scratch_q   <= scratch_d;
      presc_cnt_q <= presc_cnt_d;
      prdata_q    <= prdata_d;
    end
  end

  assign prdata = prdata_q;
  assign irq    = exp_q & ctrl_q[IE_BIT];

endmodule

// File: tb/tb_apb_timer_slave.sv
// Self-checking bench for apb_timer_slave: register table plus cycle-exact
// timer, collision, reset-abort and back-to-back transfer sequences.
`timescale 1ns/1ps
module tb_apb_timer_slave;

  localparam logic [31:0] A_CTRL    = 32'h0000_0000;
  localparam logic [31:0] A_LOAD    = 32'h0000_0004;
  localparam logic [31:0] A_COUNT   = 32'h0000_0008;
  localparam logic [31:0] A_STATUS  = 32'h0000_000C;
  localparam logic [31:0] A_PRESC   = 32'h0000_0010;
  localparam logic [31:0] A_SCRATCH = 32'h0000_0014;

  logic        hclk    = 1'b0;
  logic        hresetn = 1'b1;
  logic        psel    = 1'b0;
  logic        penable = 1'b0;
  logic        pwrite  = 1'b0;
  logic [31:0] paddr   = 32'h0;
  logic [31:0] pwdata  = 32'h0;
  logic [31:0] prdata;
  logic        irq;

  int checks = 0;
  int errors = 0;

  typedef struct {
    string       name;
    logic [31:0] exp;
  } sb_t;
  sb_t sb_q[$];

  typedef struct {
    logic        wr;
    logic [31:0] addr;
    logic [31:0] data;
    string       name;
  } vec_t;
  localparam int NV = 27;
  vec_t vecs [NV];

  apb_timer_slave dut (
    .hclk    (hclk),
    .hresetn (hresetn),
    .psel    (psel),
    .penable (penable),
    .pwrite  (pwrite),
    .paddr   (paddr),
    .pwdata  (pwdata),
    .prdata  (prdata),
    .irq     (irq)
  );

  always #5 hclk = ~hclk;

  task automatic check(input string name, input logic [31:0] act, input logic [31:0] exp);
    checks++;
    if (act !== exp) begin
      errors++;
      $display("FAIL %s: got %h, expected %h", name, act, exp);
    end
  endtask

  task automatic sb_pop_check();
    sb_t e;
    if (sb_q.size() == 0) begin
      checks++;
      errors++;
      $display("FAIL sb_underflow: got empty queue, expected one entry");
    end else begin
      e = sb_q.pop_front();
      check(e.name, prdata, e.exp);
    end
  endtask

  task automatic apb_write(input logic [31:0] addr, input logic [31:0] data);
    @(posedge hclk); #1;
    psel = 1'b1; penable = 1'b0; pwrite = 1'b1; paddr = addr; pwdata = data;
    @(posedge hclk); #1;
    penable = 1'b1;
    @(posedge hclk); #1;
    psel = 1'b0; penable = 1'b0; pwrite = 1'b0;
  endtask

  task automatic apb_read(input logic [31:0] addr, input logic [31:0] exp, input string name);
    @(posedge hclk); #1;
    psel = 1'b1; penable = 1'b0; pwrite = 1'b0; paddr = addr;
    sb_q.push_back('{name, exp});
    @(posedge hclk); #1;
    penable = 1'b1;
    sb_pop_check();
    @(posedge hclk); #1;
    psel = 1'b0; penable = 1'b0;
  endtask

  initial begin
    #200000;
    $display("FAIL watchdog: got timeout, expected end of test");
    $fatal(1, "watchdog expired");
  end

  initial begin
    vecs[0]  = '{1'b0, A_CTRL,        32'h0000_0000, "rst_ctrl"};
    vecs[1]  = '{1'b0, A_LOAD,        32'h0000_0000, "rst_load"};
    vecs[2]  = '{1'b0, A_COUNT,       32'h0000_0000, "rst_count"};
    vecs[3]  = '{1'b0, A_STATUS,      32'h0000_0000, "rst_status"};
    vecs[4]  = '{1'b0, A_PRESC,       32'h0000_0000, "rst_presc"};
    vecs[5]  = '{1'b0, A_SCRATCH,     32'h0000_0000, "rst_scratch"};
    vecs[6]  = '{1'b1, A_SCRATCH,     32'hDEAD_BEEF, "w_scratch"};
    vecs[7]  = '{1'b0, A_SCRATCH,     32'hDEAD_BEEF, "scratch_rd"};
    vecs[8]  = '{1'b0, 32'h0000_0020, 32'h0000_0000, "unmapped_rd"};
    vecs[9]  = '{1'b1, 32'h0000_0020, 32'h5555_5555, "w_unmapped"};
    vecs[10] = '{1'b0, 32'h0000_0020, 32'h0000_0000, "unmapped_rd2"};
    vecs[11] = '{1'b1, 32'h0000_0114, 32'h1234_5678, "w_foreign"};
    vecs[12] = '{1'b0, A_SCRATCH,     32'hDEAD_BEEF, "foreign_no_write"};
    vecs[13] = '{1'b0, 32'h0000_0114, 32'h0000_0000, "foreign_rd"};
    vecs[14] = '{1'b1, A_CTRL,        32'hFFFF_FFFA, "w_ctrl_mask"};
    vecs[15] = '{1'b0, A_CTRL,        32'h0000_0002, "ctrl_mask_rd"};
    vecs[16] = '{1'b1, A_CTRL,        32'h0000_0000, "w_ctrl0"};
    vecs[17] = '{1'b1, A_PRESC,       32'h0000_01FF, "w_presc"};
    vecs[18] = '{1'b0, A_PRESC,       32'h0000_00FF, "presc_width_rd"};
    vecs[19] = '{1'b1, A_PRESC,       32'h0000_0000, "w_presc0"};
    vecs[20] = '{1'b1, A_COUNT,       32'h0000_ABCD, "w_count_ro"};
    vecs[21] = '{1'b0, A_COUNT,       32'h0000_0000, "count_ro_rd"};
    vecs[22] = '{1'b1, A_LOAD,        32'h0000_0007, "w_load7"};
    vecs[23] = '{1'b0, A_LOAD,        32'h0000_0007, "load_rd"};
    vecs[24] = '{1'b0, A_COUNT,       32'h0000_0007, "load_copies_count"};
    vecs[25] = '{1'b1, A_STATUS,      32'h0000_0001, "w_status_idle"};
    vecs[26] = '{1'b0, A_STATUS,      32'h0000_0000, "status_idle_rd"};

    repeat (3) @(posedge hclk);
    #1 hresetn = 1'b0;
    check("rst_irq", {31'b0, irq}, 32'h0);

    for (int i = 0; i < NV; i++) begin
      if (vecs[i].wr) apb_write(vecs[i].addr, vecs[i].data);
      else            apb_read(vecs[i].addr, vecs[i].data, vecs[i].name);
    end

    // One-shot, cycle-exact irq
    apb_write(A_PRESC, 32'h0);
    apb_write(A_LOAD, 32'h5);
    apb_write(A_CTRL, 32'h5);
    for (int k = 1; k <= 6; k++) begin
      @(posedge hclk); #1;
      check($sformatf("oneshot_irq_c%0d", k), {31'b0, irq}, (k >= 5) ? 32'h1 : 32'h0);
    end
    apb_read(A_CTRL,   32'h4, "oneshot_en_off");
    apb_read(A_COUNT,  32'h0, "oneshot_count0");
    apb_read(A_STATUS, 32'h1, "oneshot_exp");

    // Reset in the access phase of a SCRATCH write aborts it
    @(posedge hclk); #1;
    psel = 1'b1; penable = 1'b0; pwrite = 1'b1; paddr = A_SCRATCH; pwdata = 32'h1234_5678;
    @(posedge hclk); #1;
    penable = 1'b1;
    #2 hresetn = 1'b1;
    #1;
    check("midrst_prdata", prdata, 32'h0);
    check("midrst_irq", {31'b0, irq}, 32'h0);
    @(posedge hclk); #1;
    psel = 1'b0; penable = 1'b0; pwrite = 1'b0;
    @(posedge hclk); #1;
    hresetn = 1'b0;
    apb_read(A_SCRATCH, 32'h0, "midrst_scratch");
    apb_read(A_CTRL,    32'h0, "midrst_ctrl");
    apb_read(A_LOAD,    32'h0, "midrst_load");
    apb_read(A_STATUS,  32'h0, "midrst_status");

    // One-shot countdown seen through COUNT reads
    apb_write(A_LOAD, 32'h5);
    apb_write(A_CTRL, 32'h5);
    apb_read(A_COUNT, 32'h4, "cnt_dn_4");
    apb_read(A_COUNT, 32'h1, "cnt_dn_1");
    apb_read(A_COUNT, 32'h0, "cnt_dn_0");
    apb_read(A_CTRL,  32'h4, "cnt_dn_en_off");

    // Auto-reload: expiries 8, 16, 24, 32 cycles after the CTRL commit
    apb_write(A_STATUS, 32'h1);
    apb_read(A_STATUS, 32'h0, "w1c_clear");
    apb_write(A_PRESC, 32'h3);
    apb_write(A_LOAD,  32'h2);
    apb_write(A_CTRL,  32'h3);
    apb_read(A_STATUS, 32'h0, "auto_exp_c1");
    apb_read(A_COUNT,  32'h1, "auto_cnt_c4");
    apb_read(A_STATUS, 32'h0, "auto_exp_c7");
    apb_read(A_STATUS, 32'h1, "auto_exp_c10");
    apb_read(A_COUNT,  32'h1, "auto_cnt_c13");
    apb_read(A_COUNT,  32'h2, "auto_reload_c16");
    apb_write(A_STATUS, 32'h1);
    apb_read(A_STATUS, 32'h0, "auto_w1c_c22");
    apb_read(A_STATUS, 32'h1, "auto_exp_c25");

    // W1C committing on the expiry edge (cycle 32): set wins
    repeat (2) @(posedge hclk);
    apb_write(A_STATUS, 32'h1);
    apb_read(A_STATUS, 32'h1, "collide_set_wins");
    apb_write(A_STATUS, 32'h1);
    apb_read(A_STATUS, 32'h0, "normal_w1c_c39");

    // Back-to-back write LOAD, read LOAD, read COUNT with no idle cycles
    apb_write(A_CTRL, 32'h0);
    @(posedge hclk); #1;
    psel = 1'b1; penable = 1'b0; pwrite = 1'b1; paddr = A_LOAD; pwdata = 32'h9;
    @(posedge hclk); #1;
    penable = 1'b1;
    @(posedge hclk); #1;
    penable = 1'b0; pwrite = 1'b0; paddr = A_LOAD;
    sb_q.push_back('{"b2b_load", 32'h9});
    @(posedge hclk); #1;
    penable = 1'b1;
    sb_pop_check();
    @(posedge hclk); #1;
    penable = 1'b0; paddr = A_COUNT;
    sb_q.push_back('{"b2b_count", 32'h9});
    @(posedge hclk); #1;
    penable = 1'b1;
    sb_pop_check();
    @(posedge hclk); #1;
    psel = 1'b0; penable = 1'b0;
    check("sb_empty", sb_q.size(), 32'h0);

    $display("Simulation finished: %0d checks, %0d errors", checks, errors);
    $finish;
  end

endmodule
